multicycle_ctrl: RTL and testbench
==================================

MULTICYCLE_CTRL -- requirements
Module: multicycle_ctrl

Interface
REQ-001 Parameter: none; opcode set and encodings are fixed by this document.
REQ-002 clk  in  1  single clock; all state updates on posedge.
REQ-003 rst  in  1  reset, synchronous and active-high.
REQ-004 run  in  1  permit leaving FETCH; when 0, block parks in FETCH.
REQ-005 opcode  in  7  from instruction decoder (IR-based, stable after FETCH).
REQ-006 funct3  in  3  from decoder.
REQ-007 funct7  in  7  from decoder.
REQ-008 zero  in  1  ALU zero flag, valid in BRANCH state.
REQ-009 pc_write  out  1  PC update enable, also IR latch qualifier for fetch/decode stage.
REQ-010 ir_write  out  1  IR load enable.
REQ-011 pc_src  out  2  00 PC+4, 01 PC+imm (branch/jal).
REQ-012 alu_src_b  out  1  0 rs2, 1 imm32.
REQ-013 alu_op  out  4  ALU operation code.
REQ-014 mem_read / mem_write  out  1 each  data memory strobes.
REQ-015 reg_write  out  1  register file write enable.
REQ-016 wb_sel  out  2  00 ALU result, 01 mem data, 10 imm32, 11 PC+4.
REQ-017 illegal  out  1  sticky unsupported-opcode flag.
REQ-018 state  out  4  current state encoding (debug).
REQ-019 retired  out  16  retired-instruction counter.

Function
REQ-020 States (encoding): FETCH 0, DECODE 1, EXEC_R 2, EXEC_I 3, ADDR 4, MEM_RD 5, MEM_WR 6, WB_ALU 7, WB_MEM 8, BRANCH 9, JAL 10, LUI 11, HALT 15.
REQ-021 FETCH: if run=1 assert pc_write=1, ir_write=1, pc_src=00, go DECODE; if run=0 all strobes 0, stay.
REQ-022 DECODE: no strobes; next by opcode: 0110011->EXEC_R, 0010011->EXEC_I, 0000011 or 0100011->ADDR, 1100011->BRANCH, 1101111->JAL, 0110111->LUI, any other->HALT.
REQ-023 EXEC_R: alu_src_b=0, alu_op={funct7[5],funct3}; next WB_ALU.
REQ-024 EXEC_I: alu_src_b=1, alu_op={funct3==101 ? funct7[5] : 0, funct3}; next WB_ALU.
REQ-025 WB_ALU: reg_write=1, wb_sel=00, retire; next FETCH.
REQ-026 ADDR: alu_src_b=1, alu_op=0000 (ADD); next MEM_RD if opcode=0000011, else MEM_WR.
REQ-027 MEM_RD: mem_read=1; next WB_MEM.
REQ-028 WB_MEM: reg_write=1, wb_sel=01, retire; next FETCH.
REQ-029 MEM_WR: mem_write=1, retire; next FETCH.
REQ-030 BRANCH: alu_src_b=0, alu_op=1000 (SUB); take = (funct3==000 & zero) | (funct3==001 & !zero); pc_write=take, pc_src=01; other funct3 -> not taken; retire; next FETCH.
REQ-031 JAL: reg_write=1, wb_sel=11, pc_write=1, pc_src=01, retire; next FETCH.
REQ-032 LUI: reg_write=1, wb_sel=10, retire; next FETCH.
REQ-033 HALT: illegal=1, all strobes 0, absorbing until rst; run ignored.
REQ-034 Default for every output not listed in a state: 0 (alu_op 0000, pc_src 00, wb_sel 00).
REQ-035 All control outputs are combinational from state (plus zero, funct3 in BRANCH); no mid-state glitch requirement beyond that.
REQ-036 Latency in cycles from FETCH entry with run=1: R/I 4, load 5, store 4, branch 3, jal 3, lui 3.
REQ-037 retired increments by 1 on the posedge leaving a retire state; 16-bit, wraps 0xFFFF->0x0000.
REQ-038 illegal sets on the edge entering HALT; clears only on rst.

Reset
REQ-039 rst=1 at posedge: state=FETCH, retired=0, illegal=0, all strobes 0 from the following cycle; rst dominates any transition, including mid-instruction (e.g. in MEM_RD) and in HALT.
REQ-040 rst held high: block stays in FETCH, no pc_write even if run=1.

Verification
REQ-041 rst, run=1, opcode=0110011 funct3=000 funct7=0100000 -> states 0,1,2,7,0; alu_op=1000 in EXEC_R; reg_write=1 one cycle; retired=1.
REQ-042 load (0000011) -> 0,1,4,5,8,0; mem_read=1 in MEM_RD only; wb_sel=01 with reg_write in WB_MEM; store (0100011) -> 0,1,4,6,0, mem_write exactly one cycle.
REQ-043 beq funct3=000: zero=1 -> pc_write=1, pc_src=01 in BRANCH; zero=0 -> pc_write=0; bne inverse; retired increments both cases.
REQ-044 opcode=1111111 -> DECODE then HALT, illegal=1, run toggling has no effect; rst -> FETCH, illegal=0.
REQ-045 rst asserted in MEM_RD -> next state FETCH, no WB_MEM, retired unchanged from pre-reset value cleared to 0; run=0 in FETCH for 5 cycles -> no pc_write/ir_write.
REQ-046 Preload retired to 0xFFFF via 65535 LUI instructions (or force) and retire one more -> retired=0x0000.

Source files
------------

// File: rtl/multicycle_ctrl.sv
// Multicycle control unit for a small RV32-style core.
// Walks each instruction through FETCH/DECODE/execute/write-back states,
// drives datapath strobes from the current state, counts retired
// instructions and latches a sticky flag on unsupported opcodes.
module multicycle_ctrl (
    input  logic        clk,
    input  logic        rst,
    input  logic        run,
    input  logic [6:0]  opcode,
    input  logic [2:0]  funct3,
    input  logic [6:0]  funct7,
    input  logic        zero,
    output logic        pc_write,
    output logic        ir_write,
    output logic [1:0]  pc_src,
    output logic        alu_src_b,
    output logic [3:0]  alu_op,
    output logic        mem_read,
    output logic        mem_write,
    output logic        reg_write,
    output logic [1:0]  wb_sel,
    output logic        illegal,
    output logic [3:0]  state,
    output logic [15:0] retired
);

    typedef enum logic [3:0] {
        S_FETCH  = 4'd0,
        S_DECODE = 4'd1,
        S_EXEC_R = 4'd2,
        S_EXEC_I = 4'd3,
        S_ADDR   = 4'd4,
        S_MEM_RD = 4'd5,
        S_MEM_WR = 4'd6,
        S_WB_ALU = 4'd7,
        S_WB_MEM = 4'd8,
        S_BRANCH = 4'd9,
        S_JAL    = 4'd10,
        S_LUI    = 4'd11,
        S_HALT   = 4'd15
    } state_e;

    state_e      state_q, state_d;
    logic [15:0] retired_q, retired_d;
    logic        illegal_q, illegal_d;
    logic        retire;

    // Only funct7[5] distinguishes ALU operations.
    logic unused_funct7;
    assign unused_funct7 = ^{funct7[6], funct7[4:0]};

    // State, retire counter and sticky illegal flag; reset dominates everything.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= S_FETCH;
            retired_q <= '0;
            illegal_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            retired_q <= retired_d;
            illegal_q <= illegal_d;
        end
    end

    // Next-state selection, retire accounting and illegal-entry detection.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_FETCH:  state_d = run ? S_DECODE : S_FETCH;
            S_DECODE: begin
                case (opcode)
                    7'b0110011: state_d = S_EXEC_R;
                    7'b0010011: state_d = S_EXEC_I;
                    7'b0000011,
                    7'b0100011: state_d = S_ADDR;
                    7'b1100011: state_d = S_BRANCH;
                    7'b1101111: state_d = S_JAL;
                    7'b0110111: state_d = S_LUI;
                    default:    state_d = S_HALT;
                endcase
            end
            S_EXEC_R: state_d = S_WB_ALU;
            S_EXEC_I: state_d = S_WB_ALU;
            S_ADDR:   state_d = (opcode == 7'b0000011) ? S_MEM_RD : S_MEM_WR;
            S_MEM_RD: state_d = S_WB_MEM;
            S_MEM_WR: state_d = S_FETCH;
            S_WB_ALU: state_d = S_FETCH;
            S_WB_MEM: state_d = S_FETCH;
            S_BRANCH: state_d = S_FETCH;
            S_JAL:    state_d = S_FETCH;
            S_LUI:    state_d = S_FETCH;
            S_HALT:   state_d = S_HALT;
            default:  state_d = S_HALT;
        endcase

        retire = (state_q == S_WB_ALU) || (state_q == S_WB_MEM) ||
                 (state_q == S_MEM_WR) || (state_q == S_BRANCH) ||
                 (state_q == S_JAL)    || (state_q == S_LUI);
        retired_d = retired_q + (retire ? 16'd1 : 16'd0);
        illegal_d = illegal_q | (state_d == S_HALT);
    end

    // Datapath strobes decoded from the current state.
    always_comb begin
        pc_write  = 1'b0;
        ir_write  = 1'b0;
        pc_src    = 2'b00;
        alu_src_b = 1'b0;
        alu_op    = 4'b0000;
        mem_read  = 1'b0;
        mem_write = 1'b0;
        reg_write = 1'b0;
        wb_sel    = 2'b00;
        case (state_q)
            S_FETCH: begin
                // Held reset suppresses the fetch even with run high.
                if (run && !rst) begin
                    pc_write = 1'b1;
                    ir_write = 1'b1;
                end
            end
            S_EXEC_R: alu_op = {funct7[5], funct3};
            S_EXEC_I: begin
                alu_src_b = 1'b1;
                alu_op    = {(funct3 == 3'b101) ? funct7[5] : 1'b0, funct3};
            end
            S_ADDR:   alu_src_b = 1'b1;
            S_MEM_RD: mem_read  = 1'b1;
            S_MEM_WR: mem_write = 1'b1;
            S_WB_ALU: reg_write = 1'b1;
            S_WB_MEM: begin
                reg_write = 1'b1;
                wb_sel    = 2'b01;
            end
            S_BRANCH: begin
                alu_op   = 4'b1000;
                pc_src   = 2'b01;
                pc_write = ((funct3 == 3'b000) && zero) ||
                           ((funct3 == 3'b001) && !zero);
            end
            S_JAL: begin
                reg_write = 1'b1;
                wb_sel    = 2'b11;
                pc_write  = 1'b1;
                pc_src    = 2'b01;
            end
            S_LUI: begin
                reg_write = 1'b1;
                wb_sel    = 2'b10;
            end
            default: ;
        endcase
    end

    assign state   = state_q;
    assign retired = retired_q;
    assign illegal = illegal_q;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Testbench for multicycle_ctrl: per-cycle expected output vectors are queued
// when an instruction is launched and compared as the control unit steps.
module tb_multicycle_ctrl;

    logic        clk = 1'b0;
    logic        rst, run, zero;
    logic [6:0]  opcode, funct7;
    logic [2:0]  funct3;
    logic        pc_write, ir_write, alu_src_b, mem_read, mem_write, reg_write, illegal;
    logic [1:0]  pc_src, wb_sel;
    logic [3:0]  alu_op, state;
    logic [15:0] retired;

    multicycle_ctrl dut (
        .clk(clk), .rst(rst), .run(run), .opcode(opcode), .funct3(funct3),
        .funct7(funct7), .zero(zero), .pc_write(pc_write), .ir_write(ir_write),
        .pc_src(pc_src), .alu_src_b(alu_src_b), .alu_op(alu_op),
        .mem_read(mem_read), .mem_write(mem_write), .reg_write(reg_write),
        .wb_sel(wb_sel), .illegal(illegal), .state(state), .retired(retired)
    );

    always #5 clk = ~clk;

    logic [18:0] act;
    assign act = {state, pc_write, ir_write, pc_src, alu_src_b, alu_op,
                  mem_read, mem_write, reg_write, wb_sel, illegal};

    int unsigned errors = 0;
    int unsigned checks = 0;
    logic [15:0] exp_ret = '0;
    logic [18:0] q[$];

    function automatic logic [18:0] mk(logic [3:0] st, logic pcw, logic irw,
                                       logic [1:0] pcs, logic asb, logic [3:0] op,
                                       logic mr, logic mw, logic rw,
                                       logic [1:0] wb, logic ill);
        return {st, pcw, irw, pcs, asb, op, mr, mw, rw, wb, ill};
    endfunction

    typedef struct {
        string       name;
        logic [6:0]  op;
        logic [2:0]  f3;
        logic [6:0]  f7;
        logic        z;
        int          n;
        logic [18:0] c2, c3, c4;
    } vec_t;

    vec_t tbl[17];
    int   nv = 0;

    logic [18:0] cf, cd, cidle, wba, addr;

    task automatic chk(input string nm, input logic [31:0] a, input logic [31:0] e);
        checks++;
        if (a !== e) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, a, e);
        end
    endtask

    // Compares the current outputs with the oldest queued expectation.
    task automatic expect_now(input string nm);
        logic [18:0] e;
        #1;
        if (q.size() == 0) begin
            chk({nm, "_noexp"}, 32'd1, 32'd0);
        end else begin
            e = q.pop_front();
            chk(nm, {13'd0, act}, {13'd0, e});
        end
    endtask

    task automatic add(input string nm, input logic [6:0] op, input logic [2:0] f3,
                       input logic [6:0] f7, input logic z, input int n,
                       input logic [18:0] c2, input logic [18:0] c3, input logic [18:0] c4);
        tbl[nv] = '{nm, op, f3, f7, z, n, c2, c3, c4};
        nv++;
    endtask

    task automatic run_vec(input int i);
        @(negedge clk);
        opcode = tbl[i].op; funct3 = tbl[i].f3; funct7 = tbl[i].f7; zero = tbl[i].z;
        run = 1'b1;
        q.push_back(cf);
        q.push_back(cd);
        q.push_back(tbl[i].c2);
        if (tbl[i].n >= 4) q.push_back(tbl[i].c3);
        if (tbl[i].n >= 5) q.push_back(tbl[i].c4);
        q.push_back(cidle);
        for (int k = 0; k < 8 && q.size() > 0; k++) begin
            if (k > 0) @(negedge clk);
            expect_now(tbl[i].name);
            if (q.size() == 1) run = 1'b0;
        end
        if (q.size() != 0) begin
            chk({tbl[i].name, "_timeout"}, q.size(), 0);
            q.delete();
        end
        exp_ret = exp_ret + 16'd1;
        chk({tbl[i].name, "_retired"}, {16'd0, retired}, {16'd0, exp_ret});
    endtask

    initial begin
        cf    = mk(4'd0, 1, 1, 2'b00, 0, 4'b0000, 0, 0, 0, 2'b00, 0);
        cd    = mk(4'd1, 0, 0, 2'b00, 0, 4'b0000, 0, 0, 0, 2'b00, 0);
        cidle = mk(4'd0, 0, 0, 2'b00, 0, 4'b0000, 0, 0, 0, 2'b00, 0);
        wba   = mk(4'd7, 0, 0, 2'b00, 0, 4'b0000, 0, 0, 1, 2'b00, 0);
        addr  = mk(4'd4, 0, 0, 2'b00, 1, 4'b0000, 0, 0, 0, 2'b00, 0);

        add("sub",  7'b0110011, 3'b000, 7'b0100000, 0, 4, mk(4'd2, 0, 0, 2'b00, 0, 4'b1000, 0, 0, 0, 2'b00, 0), wba, '0);
        add("add",  7'b0110011, 3'b000, 7'b0000000, 0, 4, mk(4'd2, 0, 0, 2'b00, 0, 4'b0000, 0, 0, 0, 2'b00, 0), wba, '0);
        add("sra",  7'b0110011, 3'b101, 7'b0100000, 0, 4, mk(4'd2, 0, 0, 2'b00, 0, 4'b1101, 0, 0, 0, 2'b00, 0), wba, '0);
        add("and",  7'b0110011, 3'b111, 7'b0000000, 1, 4, mk(4'd2, 0, 0, 2'b00, 0, 4'b0111, 0, 0, 0, 2'b00, 0), wba, '0);
        add("addi", 7'b0010011, 3'b000, 7'b0100000, 0, 4, mk(4'd3, 0, 0, 2'b00, 1, 4'b0000, 0, 0, 0, 2'b00, 0), wba, '0);
        add("srai", 7'b0010011, 3'b101, 7'b0100000, 0, 4, mk(4'd3, 0, 0, 2'b00, 1, 4'b1101, 0, 0, 0, 2'b00, 0), wba, '0);
        add("srli", 7'b0010011, 3'b101, 7'b0000000, 0, 4, mk(4'd3, 0, 0, 2'b00, 1, 4'b0101, 0, 0, 0, 2'b00, 0), wba, '0);
        add("slli", 7'b0010011, 3'b001, 7'b0100000, 0, 4, mk(4'd3, 0, 0, 2'b00, 1, 4'b0001, 0, 0, 0, 2'b00, 0), wba, '0);
        add("load", 7'b0000011, 3'b010, 7'b0000000, 0, 5, addr,
            mk(4'd5, 0, 0, 2'b00, 0, 4'b0000, 1, 0, 0, 2'b00, 0),
            mk(4'd8, 0, 0, 2'b00, 0, 4'b0000, 0, 0, 1, 2'b01, 0));
        add("store", 7'b0100011, 3'b010, 7'b0000000, 0, 4, addr,
            mk(4'd6, 0, 0, 2'b00, 0, 4'b0000, 0, 1, 0, 2'b00, 0), '0);
        add("beq_t", 7'b1100011, 3'b000, 7'b0000000, 1, 3, mk(4'd9, 1, 0, 2'b01, 0, 4'b1000, 0, 0, 0, 2'b00, 0), '0, '0);
        add("beq_n", 7'b1100011, 3'b000, 7'b0000000, 0, 3, mk(4'd9, 0, 0, 2'b01, 0, 4'b1000, 0, 0, 0, 2'b00, 0), '0, '0);
        add("bne_t", 7'b1100011, 3'b001, 7'b0000000, 0, 3, mk(4'd9, 1, 0, 2'b01, 0, 4'b1000, 0, 0, 0, 2'b00, 0), '0, '0);
        add("bne_n", 7'b1100011, 3'b001, 7'b0000000, 1, 3, mk(4'd9, 0, 0, 2'b01, 0, 4'b1000, 0, 0, 0, 2'b00, 0), '0, '0);
        add("blt_n", 7'b1100011, 3'b100, 7'b0000000, 1, 3, mk(4'd9, 0, 0, 2'b01, 0, 4'b1000, 0, 0, 0, 2'b00, 0), '0, '0);
        add("jal",  7'b1101111, 3'b000, 7'b0000000, 0, 3, mk(4'd10, 1, 0, 2'b01, 0, 4'b0000, 0, 0, 1, 2'b11, 0), '0, '0);
        add("lui",  7'b0110111, 3'b000, 7'b0000000, 0, 3, mk(4'd11, 0, 0, 2'b00, 0, 4'b0000, 0, 0, 1, 2'b10, 0), '0, '0);

        // Reset held with run=1 and an illegal opcode: parked in FETCH, no strobes.
        rst = 1'b1; run = 1'b1; opcode = 7'b1111111; funct3 = '0; funct7 = '0; zero = 1'b0;
        @(posedge clk);
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            q.push_back(cidle);
            expect_now("reset_hold");
        end
        chk("reset_retired", {16'd0, retired}, 32'd0);
        rst = 1'b0; run = 1'b0;

        for (int i = 0; i < nv; i++) run_vec(i);

        // Unsupported opcode: DECODE then absorbing HALT regardless of run.
        @(negedge clk);
        opcode = 7'b1111111; run = 1'b1;
        q.push_back(cf);
        q.push_back(cd);
        for (int k = 0; k < 4; k++) q.push_back(mk(4'd15, 0, 0, 2'b00, 0, 4'b0000, 0, 0, 0, 2'b00, 1));
        expect_now("illegal_fetch");
        @(negedge clk); expect_now("illegal_decode");
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            expect_now("halt");
            run = k[0];
        end
        chk("halt_retired", {16'd0, retired}, {16'd0, exp_ret});
        @(negedge clk);
        rst = 1'b1; run = 1'b1;
        q.push_back(cidle);
        @(negedge clk); expect_now("halt_reset");
        chk("halt_reset_retired", {16'd0, retired}, 32'd0);
        exp_ret = '0;
        rst = 1'b0; run = 1'b0;

        // Reset mid-load (in MEM_RD): no WB_MEM, counter cleared, then idle with run=0.
        run_vec(16);
        @(negedge clk);
        opcode = 7'b0000011; funct3 = 3'b010; run = 1'b1;
        q.push_back(cf);
        q.push_back(cd);
        q.push_back(addr);
        q.push_back(mk(4'd5, 0, 0, 2'b00, 0, 4'b0000, 1, 0, 0, 2'b00, 0));
        q.push_back(cidle);
        expect_now("rldr_fetch");
        @(negedge clk); expect_now("rldr_decode"); run = 1'b0;
        @(negedge clk); expect_now("rldr_addr");
        @(negedge clk); expect_now("rldr_memrd");
        chk("rldr_pre_retired", {16'd0, retired}, 32'd1);
        rst = 1'b1;
        @(negedge clk); expect_now("rldr_after_rst");
        chk("rldr_post_retired", {16'd0, retired}, 32'd0);
        exp_ret = '0;
        rst = 1'b0;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            q.push_back(cidle);
            expect_now("park_run0");
        end

        // Counter wrap: preload 0xFFFF, then one more retirement.
        @(negedge clk);
        force dut.retired_q = 16'hFFFF;
        @(negedge clk);
        release dut.retired_q;
        @(negedge clk);
        #1;
        chk("preload_ffff", {16'd0, retired}, 32'h0000FFFF);
        exp_ret = 16'hFFFF;
        run_vec(16);
        chk("wrap_zero", {16'd0, retired}, 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    // Absolute time bound so the run always ends.
    initial begin
        #200000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1, "timeout");
    end

endmodule
